// File: rtl/stepper_drive_multi.sv
// Multi-channel unipolar stepper driver: per-channel move FSM, step timer and
// phase sequencer driving four coils in full-step (two-phase-on) or half-step mode.
module stepper_drive_multi #(
  parameter int CHANNELS    = 2,
  parameter int CW          = 16,
  parameter int DW          = 16,
  parameter bit HOLD_TORQUE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CHANNELS-1:0]      cmd_valid,
  output logic [CHANNELS-1:0]      cmd_ready,
  input  logic [CHANNELS-1:0]      cmd_dir,
  input  logic [CHANNELS-1:0]      cmd_half,
  input  logic [CHANNELS*CW-1:0]   cmd_steps,
  input  logic [CHANNELS*DW-1:0]   cmd_div,
  input  logic [CHANNELS-1:0]      abort,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0]      done,
  output logic [4*CHANNELS-1:0]    coil
);

  // state | meaning
  // IDLE  | waiting for a command, coils held or off
  // RUN   | stepping, timer counts clk cycles per step
  // FIN   | one-cycle done pulse after completion or abort
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [3:0] phase(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        state, state_n;
    logic [2:0]    idx, idx_n, stride;
    logic [DW-1:0] timer, timer_n, div, div_n, div_in;
    logic [CW-1:0] remain, remain_n, steps_in;
    logic          dir, dir_n, half, half_n;
    logic [3:0]    coil_q, coil_n;

    assign div_in   = cmd_div[g*DW +: DW];
    assign steps_in = cmd_steps[g*CW +: CW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDLE;
        idx    <= 3'd7;
        timer  <= '0;
        remain <= '0;
        div    <= DW'(1);
        dir    <= 1'b0;
        half   <= 1'b0;
        coil_q <= 4'b0000;
      end else begin
        state  <= state_n;
        idx    <= idx_n;
        timer  <= timer_n;
        remain <= remain_n;
        div    <= div_n;
        dir    <= dir_n;
        half   <= half_n;
        coil_q <= coil_n;
      end
    end

    always_comb begin
      state_n  = state;
      idx_n    = idx;
      timer_n  = timer;
      remain_n = remain;
      div_n    = div;
      dir_n    = dir;
      half_n   = half;
      // Full-step from an even index first realigns to the odd (two-phase-on) positions.
      stride   = (half || !idx[0]) ? 3'd1 : 3'd2;
      unique case (state)
        IDLE: begin
          if (cmd_valid[g] && en) begin
            dir_n    = cmd_dir[g];
            half_n   = cmd_half[g];
            div_n    = (div_in == '0) ? DW'(1) : div_in;
            remain_n = steps_in;
            timer_n  = '0;
            state_n  = (steps_in == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (abort[g]) begin
            state_n = FIN;
          end else if (en) begin
            if (timer == div - DW'(1)) begin
              timer_n  = '0;
              idx_n    = dir ? idx - stride : idx + stride;
              remain_n = remain - CW'(1);
              if (remain == CW'(1)) state_n = FIN;
            end else begin
              timer_n = timer + DW'(1);
            end
          end
        end
        FIN:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
      coil_n = (state_n == RUN || HOLD_TORQUE) ? phase(idx_n) : 4'b0000;
    end

    assign cmd_ready[g]    = (state == IDLE) && en;
    assign busy[g]         = (state == RUN);
    assign done[g]         = (state == FIN);
    assign coil[4*g +: 4]  = en ? coil_q : 4'b0000;
  end

endmodule

// File: tb/tb_stepper_drive_multi.sv
// Bench for stepper_drive_multi: directed test-plan moves plus random moves,
// checked every cycle against an arithmetic position/schedule model.
module tb_stepper_drive_multi;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  cmd_valid, cmd_ready, cmd_dir, cmd_half, abort, busy, done;
  logic [31:0] cmd_steps, cmd_div;
  logic [7:0]  coil;

  always #5 clk = ~clk;

  stepper_drive_multi #(.CHANNELS(2), .CW(16), .DW(16), .HOLD_TORQUE(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_steps(cmd_steps), .cmd_div(cmd_div),
    .abort(abort), .busy(busy), .done(done), .coil(coil)
  );

  int passed = 0;
  int total  = 0;
  logic [3:0] ptab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                           4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [2:0] idx_m [2];
  bit act [2];
  bit p_dir [2];
  bit p_half [2];
  int p_n [2];
  int p_div [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Position after k steps, from the stepping rules in plain arithmetic.
  function automatic logic [2:0] after(input logic [2:0] p, input bit dir, input bit half, input int k);
    int delta, v;
    if (k == 0) delta = 0;
    else if (half) delta = k;
    else if (p[0]) delta = 2 * k;
    else delta = 2 * k - 1;
    v = dir ? int'(p) - delta : int'(p) + delta;
    v = ((v % 8) + 8) % 8;
    return 3'(v);
  endfunction

  function automatic int eff_div(input int c);
    return (p_div[c] == 0) ? 1 : p_div[c];
  endfunction

  task automatic set_cmd(input int c, input bit dir, input bit half, input int n, input int dv);
    p_dir[c] = dir; p_half[c] = half; p_n[c] = n; p_div[c] = dv;
  endtask

  // e = enabled cycles elapsed since the accepting edge.
  task automatic check_all(input int e);
    for (int c = 0; c < 2; c++) begin
      int d, fin, k;
      bit b, dn, rdy;
      logic [3:0] cexp;
      if (act[c]) begin
        d   = eff_div(c);
        fin = p_n[c] * d;
        k   = (e / d > p_n[c]) ? p_n[c] : e / d;
        b   = (e < fin);
        dn  = (e == fin);
        rdy = en && (e > fin);
        cexp = en ? ptab[after(idx_m[c], p_dir[c], p_half[c], k)] : 4'b0000;
      end else begin
        b = 1'b0; dn = 1'b0; rdy = en;
        cexp = en ? ptab[idx_m[c]] : 4'b0000;
      end
      chk($sformatf("ch%0d_coil e=%0d", c, e), 32'(coil[4*c +: 4]), 32'(cexp));
      chk($sformatf("ch%0d_busy e=%0d", c, e), 32'(busy[c]), 32'(b));
      chk($sformatf("ch%0d_done e=%0d", c, e), 32'(done[c]), 32'(dn));
      chk($sformatf("ch%0d_ready e=%0d", c, e), 32'(cmd_ready[c]), 32'(rdy));
    end
  endtask

  task automatic start_cmd(input bit m0, input bit m1);
    act[0] = m0; act[1] = m1; en = 1'b1;
    for (int c = 0; c < 2; c++) if (act[c]) begin
      cmd_dir[c] = p_dir[c];
      cmd_half[c] = p_half[c];
      cmd_steps[c*16 +: 16] = 16'(p_n[c]);
      cmd_div[c*16 +: 16] = 16'(p_div[c]);
    end
    cmd_valid = {m1, m0};
    #1;
    for (int c = 0; c < 2; c++) if (act[c]) chk($sformatf("ch%0d_ready_pre", c), 32'(cmd_ready[c]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 2'b00;
  endtask

  // Sample each cycle up to stop_e; en is low for edges r+1 with r in [gap_at, gap_at+gap_len).
  task automatic track(input int stop_e, input int gap_at, input int gap_len);
    int e = 0;
    int r = 0;
    while (1) begin
      check_all(e);
      if (e >= stop_e) break;
      en = !(r >= gap_at && r < gap_at + gap_len);
      @(posedge clk);
      r++;
      if (en) e++;
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  task automatic finish_move();
    for (int c = 0; c < 2; c++) if (act[c]) idx_m[c] = after(idx_m[c], p_dir[c], p_half[c], p_n[c]);
    act[0] = 1'b0; act[1] = 1'b0;
  endtask

  initial begin
    logic [2:0] idx_a;
    rst = 1'b1; en = 1'b1; cmd_valid = '0; cmd_dir = '0; cmd_half = '0;
    cmd_steps = '0; cmd_div = '0; abort = '0;
    act[0] = 1'b0; act[1] = 1'b0;
    #12;
    chk("rst_coil", 32'(coil), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idx_m[0] = 3'd7; idx_m[1] = 3'd7;
    @(posedge clk); @(negedge clk);
    check_all(0);
    en = 1'b0; #1;
    chk("en0_ready", 32'(cmd_ready), 32'd0);
    chk("en0_coil", 32'(coil), 32'd0);
    @(negedge clk); en = 1'b1;

    // ch0 forward full-step from idx 7
    set_cmd(0, 1'b0, 1'b0, 4, 3); start_cmd(1'b1, 1'b0); track(13, 0, 0); finish_move();
    // ch1 reverse half-step, then full-step forward from even idx
    set_cmd(1, 1'b1, 1'b1, 3, 1); start_cmd(1'b0, 1'b1); track(4, 0, 0); finish_move();
    set_cmd(1, 1'b0, 1'b0, 1, 1); start_cmd(1'b0, 1'b1); track(2, 0, 0); finish_move();
    // concurrent channels, different rates
    set_cmd(0, 1'b0, 1'b1, 3, 2); set_cmd(1, 1'b1, 1'b0, 2, 5);
    start_cmd(1'b1, 1'b1); track(11, 0, 0); finish_move();
    // en gap of 5 cycles mid-move
    set_cmd(0, 1'b0, 1'b0, 4, 4); start_cmd(1'b1, 1'b0); track(17, 6, 5); finish_move();

    // abort after 2 of 10 steps, on an edge where the timer would expire
    set_cmd(0, 1'b0, 1'b1, 10, 2); start_cmd(1'b1, 1'b0); track(5, 0, 0);
    abort = 2'b11;
    @(posedge clk); @(negedge clk);
    abort = 2'b00;
    idx_a = after(idx_m[0], 1'b0, 1'b1, 2);
    chk("abort_done0", 32'(done[0]), 32'd1);
    chk("abort_busy0", 32'(busy[0]), 32'd0);
    chk("abort_coil0", 32'(coil[3:0]), 32'(ptab[idx_a]));
    chk("abort_ready0", 32'(cmd_ready[0]), 32'd0);
    chk("abort_idle_ch1", 32'({busy[1], done[1]}), 32'd0);
    idx_m[0] = idx_a; act[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_ready_after", 32'(cmd_ready[0]), 32'd1);
    chk("abort_done_after", 32'(done[0]), 32'd0);
    set_cmd(0, 1'b1, 1'b0, 2, 1); start_cmd(1'b1, 1'b0); track(3, 0, 0); finish_move();

    // steps=0 and div=0
    set_cmd(1, 1'b0, 1'b0, 0, 3); start_cmd(1'b0, 1'b1); track(1, 0, 0); finish_move();
    set_cmd(0, 1'b1, 1'b1, 3, 0); start_cmd(1'b1, 1'b0); track(4, 0, 0); finish_move();

    // command held while busy is taken only once ready
    set_cmd(0, 1'b0, 1'b1, 2, 3); start_cmd(1'b1, 1'b0);
    cmd_dir[0] = 1'b1; cmd_half[0] = 1'b1; cmd_steps[15:0] = 16'd1; cmd_div[15:0] = 16'd1;
    cmd_valid[0] = 1'b1;
    track(7, 0, 0); finish_move();
    set_cmd(0, 1'b1, 1'b1, 1, 1); act[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 2'b00;
    track(2, 0, 0); finish_move();

    // random moves with optional en gaps
    for (int it = 0; it < 10; it++) begin
      int m, minfin, maxfin, ga, gl;
      bit all_nz;
      m = $urandom_range(1, 3);
      minfin = 1 << 30; maxfin = 0; all_nz = 1'b1;
      for (int c = 0; c < 2; c++) begin
        set_cmd(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 6), $urandom_range(0, 4));
        if (m[c]) begin
          if (p_n[c] == 0) all_nz = 1'b0;
          if (p_n[c] * eff_div(c) < minfin) minfin = p_n[c] * eff_div(c);
          if (p_n[c] * eff_div(c) > maxfin) maxfin = p_n[c] * eff_div(c);
        end
      end
      ga = 0; gl = 0;
      if (all_nz && minfin >= 2) begin
        ga = $urandom_range(1, minfin - 1);
        gl = $urandom_range(0, 4);
      end
      start_cmd(m[0], m[1]); track(maxfin + 1, ga, gl); finish_move();
    end

    // reset mid-move clears coils without a clock edge
    set_cmd(0, 1'b0, 1'b1, 8, 2); start_cmd(1'b1, 1'b0); track(5, 0, 0);
    rst = 1'b1; #1;
    chk("midrst_coil", 32'(coil), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; idx_m[0] = 3'd7; idx_m[1] = 3'd7; act[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
